rip_lsu_bram_port: RTL and testbench
====================================

# rip_lsu_bram_port

Load/store front end for the data-memory 2-read/1-write byte-write BRAM: accepts one RV32 load or store per cycle from the execute stage, converts byte address, funct3 and store data into the BRAM's port-1 enable, word address, byte-write mask and lane-aligned write data. One cycle later it extracts, sign- or zero-extends and returns load data. Sits between execute and the BRAM port 1; port 2 stays with instruction fetch.

## Interface
- ADDR_WIDTH, 10, BRAM word-address width (memory = 2**ADDR_WIDTH 32-bit words)
- Data width fixed at 32; byte width is B_WIDTH from rip_const (8), giving a 4-bit write mask
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  destination tag, returned unchanged
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_rd  out  5  tag of the request
- resp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
- mem_enable  out  1  to BRAM enable_1
- mem_addr  out  ADDR_WIDTH  to BRAM addr_1 = req_addr[ADDR_WIDTH+1:2]
- mem_we  out  4  to BRAM we_1
- mem_din  out  32  to BRAM din_1
- mem_dout  in  32  from BRAM dout_1

## Operation
- req_ready = rstn && (!resp_valid || resp_ready). Single response register; at most one request in flight.
- Classification of an accepted request uses priority illegal > misaligned > access fault.
  - Illegal: load funct3 011/110/111, or store funct3 with bit2 set or 011.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Access fault: addr[31:ADDR_WIDTH+2] != 0.
- mem_enable = accept && no error; combinational from the request. A request with an error never touches the BRAM.
- Store lane shift by off = addr[1:0]:
  - mem_din = SB: wdata[7:0] replicated to all 4 lanes; SH: wdata[15:0] replicated to both halves; SW: wdata.
  - mem_we = SB: 1<<off; SH: 0011 << off; SW: 1111.
- Loads: mem_we = 0000.
- Accept registers is_load, funct3, off, rd and err into the response stage; resp_valid sets.
- Response data:
  - resp_data is combinational from mem_dout and the registered fields.
  - Lane = mem_dout >> (8*off). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Stores and erroneous requests return resp_data = 0.
- Holding a response: while resp_valid && !resp_ready, req_ready is 0, so mem_enable stays 0 and the BRAM holds dout_1. resp_data therefore stays stable.
- The response register reloads on the same edge the old response is consumed, giving back-to-back throughput.
- Reset assertion, including mid-request, clears the response register and drops any pending response. A store already written to the BRAM is not undone.

## Timing
- Reset values: resp_valid 0, resp_rd 0, resp_err 00, resp_data 0, req_ready 0.
- While rstn = 0, mem_enable and mem_we are forced to 0.
- Request accepted in cycle T: BRAM access is on the edge ending T; resp_valid is high in T+1 with valid resp_data.
- Load-to-use latency is 1 cycle; throughput is 1 request/cycle when resp_ready is held high.
- Store followed by a load to the same word in T+1: the load sees the new data, because the BRAM write completes on the edge ending T.
- No combinational path from resp_ready to the mem_* outputs other than through req_ready.

## Test plan
- SW 0x11223344 to 0x10, then LW 0x10 → mem_we 1111; resp_data 0x11223344, err 00, one cycle after the load is accepted.
- SB 0xA5 to 0x13, then LB 0x13 and LBU 0x13 → mem_we 1000, mem_din 0xA5A5A5A5; LB = 0xFFFFFFA5, LBU = 0x000000A5.
- SH 0x8001 to 0x12, then LH/LHU 0x12 → mem_we 1100; LH 0xFFFF8001, LHU 0x00008001. LW 0x10 returns 0x80013344 after the earlier SW.
- LW 0x11, LH 0x03, SW 0x1000 (ADDR_WIDTH=10), load funct3 011 → err 01, 01, 10, 11 respectively; mem_enable stays 0 throughout; resp_data 0.
- Stream 8 loads with resp_ready low for 3 cycles mid-stream → req_ready 0 and mem_enable 0 while stalled; resp_data stable; all 8 responses in order with correct tags.
- Drop rstn while resp_valid = 1 and resp_ready = 0 → resp_valid falls asynchronously; after release the first new request completes normally.

Source files
------------

// File: rtl/rip_lsu_bram_port.sv
// RV32 load/store front end for BRAM port 1: lane-aligns stores, classifies
// errors, and extends load data one cycle after acceptance.
`timescale 1ns/1ps
module rip_lsu_bram_port #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_rd,
    output logic [1:0]            resp_err,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    localparam int unsigned B_WIDTH = 8;
    localparam int unsigned D_WIDTH = 32;
    localparam int unsigned M_WIDTH = D_WIDTH / B_WIDTH;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FAULT    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    logic               resp_valid_q, resp_valid_d;
    logic               is_load_q,    is_load_d;
    logic [2:0]         funct3_q,     funct3_d;
    logic [1:0]         off_q,        off_d;
    logic [4:0]         rd_q,         rd_d;
    err_e               err_q,        err_d;

    logic               accept;
    logic               illegal;
    logic               misalign;
    logic               fault;
    err_e               req_err;
    logic [M_WIDTH-1:0] we_mask;
    logic [31:0]        lane;

    assign req_ready = rstn && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;

    // Request classification; illegal beats misaligned beats access fault.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        if (req_we) begin
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        case (req_funct3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        fault = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        if (illegal) begin
            req_err = ERR_ILLEGAL;
        end else if (misalign) begin
            req_err = ERR_MISALIGN;
        end else if (fault) begin
            req_err = ERR_FAULT;
        end else begin
            req_err = ERR_OK;
        end
    end

    // Store lane replication and byte-enable mask.
    always_comb begin
        mem_din = req_wdata;
        we_mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                mem_din = {4{req_wdata[7:0]}};
                we_mask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                mem_din = {2{req_wdata[15:0]}};
                we_mask = 4'b0011 << req_addr[1:0];
            end
            default: begin
                mem_din = req_wdata;
                we_mask = 4'b1111;
            end
        endcase
    end

    assign mem_enable = accept && (req_err == ERR_OK);
    assign mem_addr   = req_addr[ADDR_WIDTH+1:2];
    assign mem_we     = (mem_enable && req_we) ? we_mask : 4'b0000;

    // Response stage next state: reload on accept, else drain on consume.
    always_comb begin
        resp_valid_d = resp_valid_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        err_d        = err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            is_load_d    = !req_we;
            funct3_d     = req_funct3;
            off_d        = req_addr[1:0];
            rd_d         = req_rd;
            err_d        = req_err;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            rd_q         <= 5'd0;
            err_q        <= ERR_OK;
        end else begin
            resp_valid_q <= resp_valid_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
        end
    end

    // Load extraction works off the BRAM output, which holds while stalled.
    always_comb begin
        lane      = mem_dout >> {off_q, 3'b000};
        resp_data = 32'd0;
        if (resp_valid_q && is_load_q && (err_q == ERR_OK)) begin
            case (funct3_q)
                3'b000:  resp_data = {{24{lane[7]}}, lane[7:0]};
                3'b001:  resp_data = {{16{lane[15]}}, lane[15:0]};
                3'b100:  resp_data = {24'd0, lane[7:0]};
                3'b101:  resp_data = {16'd0, lane[15:0]};
                default: resp_data = lane;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_rip_lsu_bram_port.sv
// Bench for rip_lsu_bram_port: BRAM model plus a byte-addressed reference
// memory that predicts every mem_* output and response.
`timescale 1ns/1ps
module tb_rip_lsu_bram_port;

    localparam int unsigned AW     = 10;
    localparam int unsigned NWORDS = 1 << AW;
    localparam int unsigned NBYTES = 4 * NWORDS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic [4:0]    req_rd = 5'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_data;
    logic [4:0]    resp_rd;
    logic [1:0]    resp_err;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rmem [NBYTES];
    logic [31:0] bram [NWORDS];

    rip_lsu_bram_port #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_enable (mem_enable),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Read-first byte-write BRAM, port 1.
    always @(posedge clk) begin
        if (mem_enable) begin
            mem_dout <= bram[mem_addr];
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 2'b11;
        if ((a % m_size(f3)) != 0) return 2'b01;
        if (a >= NBYTES) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        int          base;
        logic [31:0] v;
        n    = m_size(f3);
        base = int'(a);
        v    = 32'd0;
        for (int i = 0; i < int'(n); i++) v[8*i +: 8] = rmem[base + i];
        if (!f3[2] && n < 4 && v[8*n-1]) begin
            for (int i = int'(n); i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // One isolated request with full prediction of the port and the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] odata, output logic [3:0] owe,
                          output logic [31:0] odin);
        logic [1:0]  e;
        int unsigned n;
        int          off;
        logic [3:0]  xwe;
        logic [31:0] xdin;
        logic [31:0] xdata;
        e     = m_err(we, f3, a);
        n     = m_size(f3);
        off   = int'(a[1:0]);
        xwe   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (we && e == 2'b00 && i >= off && i < off + int'(n)) xwe[i] = 1'b1;
        end
        xdin  = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        xdata = (!we && e == 2'b00) ? m_load(f3, a) : 32'd0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        chk("mem_enable", 32'(mem_enable), 32'(e == 2'b00));
        chk("mem_we", 32'(mem_we), 32'(xwe));
        if (e == 2'b00) chk("mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
        if (we && e == 2'b00) chk("mem_din", mem_din, xdin);
        owe  = mem_we;
        odin = mem_din;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (we && e == 2'b00) begin
            for (int i = 0; i < int'(n); i++) rmem[int'(a) + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rd", 32'(resp_rd), 32'(rd));
        chk("resp_err", 32'(resp_err), 32'(e));
        chk("resp_data", resp_data, xdata);
        odata = resp_data;
        @(posedge clk);
        #1;
        chk("resp_drain", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] d;
    logic [3:0]  w;
    logic [31:0] din;
    logic [31:0] eq_data[$];
    logic [4:0]  eq_rd[$];
    logic [2:0]  sf3 [8];
    logic [31:0] sad [8];
    logic [2:0]  ld_f3 [5];

    initial begin
        int sent;
        int got;
        int nstall;
        logic acc;
        logic cons;
        logic [31:0] v;

        for (int i = 0; i < int'(NWORDS); i++) begin
            v = $urandom;
            bram[i] <= v;
            for (int b = 0; b < 4; b++) rmem[4*i + b] = v[8*b +: 8];
        end

        // Reset state, with a store presented to check forcing.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
        #3;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed stores and loads.
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 5'd1, d, w, din);
        chk("sw_we", 32'(w), 32'hF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, d, w, din);
        chk("lw10", d, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h13, 32'hA5, 5'd3, d, w, din);
        chk("sb_we", 32'(w), 32'h8);
        chk("sb_din", din, 32'hA5A5A5A5);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, d, w, din);
        chk("lb13", d, 32'hFFFFFFA5);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd5, d, w, din);
        chk("lbu13", d, 32'h000000A5);
        do_req(1'b1, 3'b001, 32'h12, 32'h8001, 5'd6, d, w, din);
        chk("sh_we", 32'(w), 32'hC);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd7, d, w, din);
        chk("lh12", d, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd8, d, w, din);
        chk("lhu12", d, 32'h00008001);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd9, d, w, din);
        chk("lw10_after", d, 32'h80013344);

        // Error classes; do_req checks mem_enable stays low and data is 0.
        do_req(1'b0, 3'b010, 32'h11, 32'h0, 5'd10, d, w, din);
        do_req(1'b0, 3'b001, 32'h03, 32'h0, 5'd11, d, w, din);
        do_req(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 5'd12, d, w, din);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 5'd13, d, w, din);
        do_req(1'b1, 3'b011, 32'h11, 32'h0, 5'd14, d, w, din);

        // Reset while a response is held.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd21;
        resp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", resp_data, 32'h80013344);
        #2;
        rstn = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        #1;
        chk("arst_valid", 32'(resp_valid), 32'd0);
        chk("arst_rd", 32'(resp_rd), 32'd0);
        chk("arst_data", resp_data, 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_mem_enable", 32'(mem_enable), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        rstn = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd22, d, w, din);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd23, d, w, din);
        chk("post_rst_lw", d, 32'h80013344);

        // Stream of 8 loads with a 3-cycle response stall.
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        for (int k = 0; k < 8; k++) begin
            sf3[k] = ld_f3[$urandom_range(0, 4)];
            sad[k] = ($urandom_range(0, NWORDS - 1) * 4) |
                     (32'($urandom_range(0, 3)) & ~(32'(m_size(sf3[k])) - 32'd1));
        end
        sent = 0; got = 0; nstall = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            resp_ready = !(cyc >= 4 && cyc < 7);
            if (sent < 8) begin
                req_valid = 1'b1; req_we = 1'b0;
                req_funct3 = sf3[sent]; req_addr = sad[sent]; req_rd = 5'(sent + 16);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (resp_valid && !resp_ready) begin
                nstall++;
                chk("stall_req_ready", 32'(req_ready), 32'd0);
                chk("stall_mem_enable", 32'(mem_enable), 32'd0);
                if (eq_data.size() > 0) chk("stall_data", resp_data, eq_data[0]);
            end
            acc  = req_valid && req_ready;
            cons = resp_valid && resp_ready;
            if (cons) begin
                if (eq_data.size() == 0) begin
                    chk("stream_spurious", 32'(resp_rd), 32'hFFFFFFFF);
                end else begin
                    chk("stream_data", resp_data, eq_data.pop_front());
                    chk("stream_rd", 32'(resp_rd), 32'(eq_rd.pop_front()));
                    got++;
                end
            end
            if (acc) begin
                eq_data.push_back(m_load(sf3[sent], sad[sent]));
                eq_rd.push_back(5'(sent + 16));
                sent++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd8);
        chk("stall_cycles", 32'(nstall), 32'd3);

        // Randomized mix of loads and stores, legal and illegal.
        for (int k = 0; k < 80; k++) begin
            logic        rw;
            logic [2:0]  rf3;
            logic [31:0] ra;
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rf3 = rw ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0) ra = ra & ~(32'(m_size(rf3)) - 32'd1);
            do_req(rw, rf3, ra, $urandom, 5'($urandom_range(0, 31)), d, w, din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
